// File: rtl/jtag_dr_bridge.sv
// JTAG user-DR to system-clock bridge: one write and one read response in flight,
// each crossing carried by a toggle handshake with multi-flop synchronisers.
module jtag_dr_bridge #(
    parameter int C_WIDTH     = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tck,
    input  logic               jtag_sel,
    input  logic               jtag_capture,
    input  logic               jtag_shift,
    input  logic               jtag_update,
    input  logic               jtag_tdi,
    output logic               jtag_tdo,
    output logic [C_WIDTH-1:0] wr_data,
    output logic               wr_valid,
    input  logic               wr_ready,
    input  logic [C_WIDTH-1:0] rd_data,
    input  logic               rd_valid,
    output logic               rd_ready
);
    localparam int L = C_WIDTH + 2;

    // TCK domain
    logic [L-1:0]           sr;
    logic                   overflow;
    logic                   cap_full;
    logic                   wr_req_t;
    logic                   rd_ack_t;
    logic [C_WIDTH-1:0]     wr_hold;
    logic [SYNC_STAGES-1:0] wr_ack_sync;
    logic [SYNC_STAGES-1:0] rd_req_sync;
    logic                   wr_busy_tck;
    logic                   rd_full_tck;
    logic                   cap_en;
    logic                   shift_en;
    logic                   wr_cmd;
    logic                   ack_cmd;
    logic                   ovf_set;

    // clk domain
    logic                   wr_ack_c;
    logic                   wr_req_seen;
    logic                   rd_req_c;
    logic [SYNC_STAGES-1:0] wr_req_sync;
    logic [SYNC_STAGES-1:0] rd_ack_sync;
    logic [C_WIDTH-1:0]     rd_buf;

    assign wr_busy_tck = wr_req_t ^ wr_ack_sync[SYNC_STAGES-1];
    assign rd_full_tck = rd_req_sync[SYNC_STAGES-1] ^ rd_ack_t;
    assign cap_en      = jtag_capture & jtag_sel;
    assign shift_en    = jtag_shift & jtag_sel;
    assign wr_cmd      = jtag_update & jtag_sel & sr[L-1];
    assign ack_cmd     = jtag_update & jtag_sel & sr[C_WIDTH];
    assign ovf_set     = wr_cmd & wr_busy_tck;
    assign jtag_tdo    = sr[0];

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            sr          <= '0;
            overflow    <= 1'b0;
            cap_full    <= 1'b0;
            wr_req_t    <= 1'b0;
            rd_ack_t    <= 1'b0;
            wr_hold     <= '0;
            wr_ack_sync <= '0;
            rd_req_sync <= '0;
        end else begin
            wr_ack_sync <= {wr_ack_sync[SYNC_STAGES-2:0], wr_ack_c};
            rd_req_sync <= {rd_req_sync[SYNC_STAGES-2:0], rd_req_c};

            // capture wins over shift; rd_buf is stable whenever rd_full_tck is seen set
            if (cap_en) begin
                sr       <= {overflow, rd_full_tck, rd_buf & {C_WIDTH{rd_full_tck}}};
                cap_full <= rd_full_tck;
            end else if (shift_en) begin
                sr <= {jtag_tdi, sr[L-1:1]};
            end

            overflow <= ovf_set | (overflow & ~cap_en);

            if (wr_cmd && !wr_busy_tck) begin
                wr_hold  <= sr[C_WIDTH-1:0];
                wr_req_t <= ~wr_req_t;
            end

            // an ack only frees the entry that the host actually captured
            if (ack_cmd && cap_full && rd_full_tck) begin
                rd_ack_t <= ~rd_ack_t;
            end
        end
    end

    assign rd_ready = ~(rd_req_c ^ rd_ack_sync[SYNC_STAGES-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_req_sync <= '0;
            rd_ack_sync <= '0;
            wr_req_seen <= 1'b0;
            wr_ack_c    <= 1'b0;
            wr_valid    <= 1'b0;
            wr_data     <= '0;
            rd_req_c    <= 1'b0;
            rd_buf      <= '0;
        end else begin
            wr_req_sync <= {wr_req_sync[SYNC_STAGES-2:0], wr_req_t};
            rd_ack_sync <= {rd_ack_sync[SYNC_STAGES-2:0], rd_ack_t};

            if (wr_valid && wr_ready) begin
                wr_valid <= 1'b0;
                wr_ack_c <= ~wr_ack_c;
            end else if (!wr_valid && (wr_req_sync[SYNC_STAGES-1] != wr_req_seen)) begin
                wr_data     <= wr_hold;
                wr_valid    <= 1'b1;
                wr_req_seen <= wr_req_sync[SYNC_STAGES-1];
            end

            if (rd_valid && rd_ready) begin
                rd_buf   <= rd_data;
                rd_req_c <= ~rd_req_c;
            end
        end
    end
endmodule

// File: tb/tb_jtag_dr_bridge.sv
// Randomised bench for jtag_dr_bridge against a transaction-level model of the
// host-visible DR contents and the valid/ready sides.
`timescale 1ns/1ps
module tb_jtag_dr_bridge;
    localparam int C_WIDTH     = 32;
    localparam int SYNC_STAGES = 3;
    localparam int L           = C_WIDTH + 2;

    logic               clk = 1'b0;
    logic               tck = 1'b0;
    logic               reset = 1'b1;
    logic               jtag_sel = 1'b0;
    logic               jtag_capture = 1'b0;
    logic               jtag_shift = 1'b0;
    logic               jtag_update = 1'b0;
    logic               jtag_tdi = 1'b0;
    logic               jtag_tdo;
    logic [C_WIDTH-1:0] wr_data;
    logic               wr_valid;
    logic               wr_ready = 1'b0;
    logic [C_WIDTH-1:0] rd_data = '0;
    logic               rd_valid = 1'b0;
    logic               rd_ready;

    int checks = 0;
    int passed = 0;

    // model state
    logic               m_wr_busy = 1'b0;
    logic [C_WIDTH-1:0] m_wr_data = '0;
    logic               m_ovf = 1'b0;
    logic               m_rd_full = 1'b0;
    logic [C_WIDTH-1:0] m_rd_data = '0;
    logic               m_cap_full = 1'b0;

    time t_upd = 0;
    time t_wv  = 0;
    time t_rr  = 0;
    int  wv_rises = 0;

    jtag_dr_bridge #(.C_WIDTH(C_WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .tck(tck),
        .jtag_sel(jtag_sel), .jtag_capture(jtag_capture), .jtag_shift(jtag_shift),
        .jtag_update(jtag_update), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    // edges never coincide: clk rises at odd multiples of 5 ns, tck at multiples of 16 ns
    always #5 clk = ~clk;
    always #16 tck = ~tck;

    always @(posedge wr_valid) begin
        t_wv = $time;
        wv_rises++;
    end
    always @(posedge rd_ready) t_rr = $time;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic model_capture(output logic [L-1:0] exp);
        exp = {m_ovf, m_rd_full, (m_rd_full ? m_rd_data : {C_WIDTH{1'b0}})};
        m_ovf = 1'b0;
        m_cap_full = m_rd_full;
    endtask

    task automatic model_update(input logic [L-1:0] cmd);
        if (cmd[L-1]) begin
            if (m_wr_busy) m_ovf = 1'b1;
            else begin
                m_wr_busy = 1'b1;
                m_wr_data = cmd[C_WIDTH-1:0];
            end
        end
        if (cmd[C_WIDTH] && m_cap_full && m_rd_full) m_rd_full = 1'b0;
    endtask

    task automatic tap_capture_shift(input logic [L-1:0] din, output logic [L-1:0] dout);
        @(negedge tck);
        jtag_sel = 1'b1;
        jtag_capture = 1'b1;
        @(negedge tck);
        jtag_capture = 1'b0;
        jtag_shift = 1'b1;
        for (int i = 0; i < L; i++) begin
            jtag_tdi = din[i];
            dout[i] = jtag_tdo;
            @(negedge tck);
        end
        jtag_shift = 1'b0;
    endtask

    task automatic tap_update();
        @(negedge tck);
        jtag_sel = 1'b1;
        jtag_update = 1'b1;
        @(posedge tck);
        t_upd = $time;
        @(negedge tck);
        jtag_update = 1'b0;
        jtag_sel = 1'b0;
    endtask

    task automatic scan(input logic [L-1:0] din, input string name, output logic [L-1:0] dout);
        logic [L-1:0] exp;
        model_capture(exp);
        tap_capture_shift(din, dout);
        checks++;
        if (dout !== exp) $display("FAIL %s: captured dr got %h required %h", name, dout, exp);
        else passed++;
        tap_update();
        model_update(din);
    endtask

    task automatic settle();
        repeat (8) @(posedge tck);
        @(negedge clk);
    endtask

    task automatic check_steady(input string name);
        checks++;
        if (wr_valid !== m_wr_busy) $display("FAIL %s wr_valid: got %b required %b", name, wr_valid, m_wr_busy);
        else passed++;
        checks++;
        if (rd_ready !== ~m_rd_full) $display("FAIL %s rd_ready: got %b required %b", name, rd_ready, ~m_rd_full);
        else passed++;
    endtask

    task automatic send_resp(input logic [C_WIDTH-1:0] d, input string name);
        @(negedge clk);
        checks++;
        if (rd_ready !== ~m_rd_full) $display("FAIL %s rd_ready before: got %b required %b", name, rd_ready, ~m_rd_full);
        else passed++;
        if (!m_rd_full) begin
            m_rd_full = 1'b1;
            m_rd_data = d;
        end
        rd_valid = 1'b1;
        rd_data = d;
        @(negedge clk);
        rd_valid = 1'b0;
    endtask

    task automatic wr_handshake(input string name);
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b1 || wr_data !== m_wr_data)
            $display("FAIL %s write: got valid %b data %h required valid 1 data %h", name, wr_valid, wr_data, m_wr_data);
        else passed++;
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        checks++;
        if (wr_valid !== 1'b0) $display("FAIL %s wr_valid after accept: got %b required 0", name, wr_valid);
        else passed++;
        m_wr_busy = 1'b0;
    endtask

    task automatic wait_wr_valid();
        for (int n = 0; n < 20; n++) begin
            if (wr_valid === 1'b1) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #20;
        checks++;
        if (wr_valid !== 1'b0 || wr_data !== '0 || rd_ready !== 1'b1 || jtag_tdo !== 1'b0)
            $display("FAIL reset_hold: got wv %b wd %h rr %b tdo %b required 0 0 1 0", wr_valid, wr_data, rd_ready, jtag_tdo);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (wr_valid !== 1'b0 || rd_ready !== 1'b1)
            $display("FAIL reset_release: got wv %b rr %b required 0 1", wr_valid, rd_ready);
        else passed++;
    endtask

    task automatic test_write();
        logic [L-1:0] dout;
        scan({1'b1, 1'b0, 32'hDEADBEEF}, "write_scan", dout);
        wait_wr_valid();
        checks++;
        if (t_wv <= t_upd || (t_wv - t_upd) > 10 * (SYNC_STAGES + 2))
            $display("FAIL write_latency: wr_valid rise at %0t update at %0t required within %0d clk", t_wv, t_upd, SYNC_STAGES + 2);
        else passed++;
        checks++;
        if (wr_data !== 32'hDEADBEEF) $display("FAIL write_data: got %h required deadbeef", wr_data);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (wr_valid !== 1'b1 || wr_data !== 32'hDEADBEEF)
                $display("FAIL write_hold: got valid %b data %h required 1 deadbeef", wr_valid, wr_data);
            else passed++;
        end
        wr_handshake("write");
        settle();
        check_steady("write_done");
    endtask

    task automatic test_overflow();
        logic [L-1:0] dout;
        int rises0;
        rises0 = wv_rises;
        scan({1'b1, 1'b0, 32'h1}, "ovf_first", dout);
        wait_wr_valid();
        scan({1'b1, 1'b0, 32'h2}, "ovf_second", dout);
        settle();
        check_steady("ovf_pending");
        scan({L{1'b0}}, "ovf_set_capture", dout);
        checks++;
        if (dout[L-1] !== 1'b1) $display("FAIL ovf_flag_set: got %b required 1", dout[L-1]);
        else passed++;
        scan({L{1'b0}}, "ovf_clear_capture", dout);
        checks++;
        if (dout[L-1] !== 1'b0) $display("FAIL ovf_flag_clear: got %b required 0", dout[L-1]);
        else passed++;
        wr_handshake("ovf_only_first");
        settle();
        check_steady("ovf_done");
        checks++;
        if (wv_rises - rises0 !== 1) $display("FAIL ovf_presented: got %0d writes required 1", wv_rises - rises0);
        else passed++;
    endtask

    task automatic test_read();
        logic [L-1:0] dout;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_data = 32'hCAFEF00D;
        m_rd_full = 1'b1;
        m_rd_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        checks++;
        if (rd_ready !== 1'b0) $display("FAIL read_ready_drop: got %b required 0", rd_ready);
        else passed++;
        @(negedge clk);
        rd_valid = 1'b0;
        settle();
        scan({1'b0, 1'b1, 32'h0}, "read_capture", dout);
        checks++;
        if (dout[3:0] !== 4'b1101) $display("FAIL read_tdo_order: got %b required 1101", dout[3:0]);
        else passed++;
        for (int n = 0; n < 20; n++) begin
            if (rd_ready === 1'b1) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (t_rr <= t_upd || (t_rr - t_upd) > 10 * (2 * SYNC_STAGES + 2))
            $display("FAIL read_ready_return: rise at %0t update at %0t required within %0d clk", t_rr, t_upd, 2 * SYNC_STAGES + 2);
        else passed++;
        settle();
        check_steady("read_done");
    endtask

    task automatic test_ack_ignored();
        logic [L-1:0] din, dout, exp;
        logic [C_WIDTH-1:0] d;
        d = $urandom;
        din = {1'b0, 1'b1, {C_WIDTH{1'b0}}};
        model_capture(exp);
        tap_capture_shift(din, dout);
        checks++;
        if (dout !== exp) $display("FAIL ackign_empty_capture: got %h required %h", dout, exp);
        else passed++;
        send_resp(d, "ackign_resp");
        settle();
        tap_update();
        model_update(din);
        settle();
        check_steady("ackign_after_update");
        scan(din, "ackign_recapture", dout);
        settle();
        check_steady("ackign_freed");
    endtask

    task automatic test_wr_and_ack();
        logic [L-1:0] dout;
        logic [C_WIDTH-1:0] w;
        send_resp($urandom, "both_resp");
        settle();
        w = $urandom;
        scan({1'b1, 1'b1, w}, "both_scan", dout);
        settle();
        check_steady("both_after");
        wr_handshake("both");
        settle();
        check_steady("both_done");
    endtask

    task automatic test_random();
        logic [L-1:0] dout;
        logic [C_WIDTH-1:0] d;
        bit w, a;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    w = 1'($urandom_range(0, 1));
                    a = 1'($urandom_range(0, 1));
                    d = $urandom;
                    scan({w, a, d}, "rand_scan", dout);
                end
                1: if (m_wr_busy) wr_handshake("rand_wr");
                default: send_resp($urandom, "rand_resp");
            endcase
            settle();
            check_steady("rand_step");
        end
        if (m_wr_busy) wr_handshake("rand_drain_wr");
        if (m_rd_full) scan({1'b0, 1'b1, {C_WIDTH{1'b0}}}, "rand_drain_rd", dout);
        if (m_ovf) scan({L{1'b0}}, "rand_drain_ovf", dout);
        settle();
        check_steady("rand_drained");
    endtask

    task automatic test_reset_mid();
        logic [L-1:0] dout;
        int rises0;
        scan({1'b1, 1'b0, 32'h12345678}, "rst_write", dout);
        send_resp($urandom, "rst_resp");
        settle();
        scan({1'b1, 1'b0, 32'h0BAD0BAD}, "rst_ovf_write", dout);
        settle();
        check_steady("rst_before");
        rises0 = wv_rises;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #3;
        checks++;
        if (wr_valid !== 1'b0 || rd_ready !== 1'b1 || jtag_tdo !== 1'b0 || wr_data !== '0)
            $display("FAIL rst_mid_outputs: got wv %b rr %b tdo %b wd %h required 0 1 0 0", wr_valid, rd_ready, jtag_tdo, wr_data);
        else passed++;
        #30;
        @(negedge clk);
        reset = 1'b0;
        m_wr_busy = 1'b0;
        m_ovf = 1'b0;
        m_rd_full = 1'b0;
        m_cap_full = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (wv_rises !== rises0) $display("FAIL rst_no_spurious: got %0d extra writes required 0", wv_rises - rises0);
        else passed++;
        check_steady("rst_after");
        scan({L{1'b0}}, "rst_capture_clean", dout);
    endtask

    initial begin
        test_reset();
        test_write();
        test_overflow();
        test_read();
        test_ack_ignored();
        test_wr_and_ack();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
